// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, CTRL field positions, mode codes and channel FSM states
package timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IM     = 3;
  localparam int CTRL_PRESC  = 8;
  localparam int STATUS_PEND = 0;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_AUTO    = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } timer_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] nxt,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = nxt[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counter channel: prescaler, FSM, sticky pending flag
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl,
  input  logic        wr_preset,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] ctrl_rd,
  output logic [31:0] preset_rd,
  output logic [31:0] count_rd,
  output logic [31:0] status_rd,
  output logic        irq
);

  timer_state_e       state, state_nxt;
  logic               en, en_nxt;
  logic [1:0]         mode, mode_nxt;
  logic               im, im_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt;
  logic [PRESC_W-1:0] presc_cnt, presc_cnt_nxt;
  logic [CNT_W-1:0]   preset, preset_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               pend, pend_nxt;
  logic [31:0]        preset_ext, preset_merged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      en        <= 1'b0;
      mode      <= MODE_ONESHOT;
      im        <= 1'b0;
      presc     <= '0;
      presc_cnt <= '0;
      preset    <= '0;
      count     <= '0;
      pend      <= 1'b0;
    end else begin
      state     <= state_nxt;
      en        <= en_nxt;
      mode      <= mode_nxt;
      im        <= im_nxt;
      presc     <= presc_nxt;
      presc_cnt <= presc_cnt_nxt;
      preset    <= preset_nxt;
      count     <= count_nxt;
      pend      <= pend_nxt;
    end
  end

  // A CPU write to CTRL byte 0 overrides the one-shot EN clear of the INT state.
  always_comb begin
    en_nxt    = en;
    mode_nxt  = mode;
    im_nxt    = im;
    presc_nxt = presc;
    if (state == ST_INT && mode != MODE_AUTO) en_nxt = 1'b0;
    if (wr_ctrl && byteen[0]) begin
      en_nxt   = wdata[CTRL_EN];
      mode_nxt = wdata[CTRL_MODE +: 2];
      im_nxt   = wdata[CTRL_IM];
    end
    if (wr_ctrl && byteen[1]) presc_nxt = wdata[CTRL_PRESC +: PRESC_W];
  end

  always_comb begin
    preset_ext              = '0;
    preset_ext[CNT_W-1:0]   = preset;
    preset_merged           = merge_bytes(preset_ext, wdata, byteen);
    preset_nxt              = wr_preset ? preset_merged[CNT_W-1:0] : preset;
  end

  // Setting from INT takes priority over a same-cycle W1C.
  always_comb begin
    pend_nxt = pend;
    if (wr_status && byteen[0] && wdata[STATUS_PEND]) pend_nxt = 1'b0;
    if (state == ST_INT) pend_nxt = 1'b1;
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    presc_cnt_nxt = presc_cnt;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_LOAD;
      ST_LOAD: begin
        count_nxt     = preset;
        presc_cnt_nxt = '0;
        state_nxt     = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (presc_cnt == presc) begin
          presc_cnt_nxt = '0;
          if (count > CNT_W'(1)) begin
            count_nxt = count - CNT_W'(1);
          end else begin
            count_nxt = '0;
            state_nxt = ST_INT;
          end
        end else begin
          presc_cnt_nxt = presc_cnt + PRESC_W'(1);
        end
      end
      ST_INT: state_nxt = (mode == MODE_AUTO && en_nxt) ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_rd                        = '0;
    ctrl_rd[CTRL_EN]               = en;
    ctrl_rd[CTRL_MODE +: 2]        = mode;
    ctrl_rd[CTRL_IM]               = im;
    ctrl_rd[CTRL_PRESC +: PRESC_W] = presc;
    preset_rd                      = '0;
    preset_rd[CNT_W-1:0]           = preset;
    count_rd                       = '0;
    count_rd[CNT_W-1:0]            = count;
    status_rd                      = '0;
    status_rd[STATUS_PEND]         = pend;
  end

  assign irq = pend & im;

endmodule

// File: rtl/timer_array.sv
// rtl/timer_array.sv - N-channel memory-mapped timer: address decode, read mux, irq aggregation
module timer_array
  import timer_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      addr,
  input  logic            we,
  input  logic [3:0]      byteen,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [N_CH-1:0] irq,
  output logic            irq_any
);

  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [1:0]  unused_addr_lsb;
  logic [31:0] ctrl_rd   [N_CH];
  logic [31:0] preset_rd [N_CH];
  logic [31:0] count_rd  [N_CH];
  logic [31:0] status_rd [N_CH];

  assign ch_sel          = addr[6:4];
  assign reg_sel         = addr[3:2];
  assign unused_addr_lsb = addr[1:0];

  // Channels that do not exist never match ch_sel, so their writes drop and reads return 0.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic hit;
    assign hit = we && (ch_sel == 3'(i));

    timer_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .wr_ctrl   (hit && reg_sel == REG_CTRL),
      .wr_preset (hit && reg_sel == REG_PRESET),
      .wr_status (hit && reg_sel == REG_STATUS),
      .wdata     (wdata),
      .byteen    (byteen),
      .ctrl_rd   (ctrl_rd[i]),
      .preset_rd (preset_rd[i]),
      .count_rd  (count_rd[i]),
      .status_rd (status_rd[i]),
      .irq       (irq[i])
    );
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_sel == 3'(i)) begin
        case (reg_sel)
          REG_CTRL:   rdata = ctrl_rd[i];
          REG_PRESET: rdata = preset_rd[i];
          REG_COUNT:  rdata = count_rd[i];
          REG_STATUS: rdata = status_rd[i];
        endcase
      end
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_array.sv
// tb/tb_timer_array.sv - scoreboard bench for timer_array (N_CH=2)
module tb_timer_array;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  irq;
  logic        irq_any;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  timer_array #(.N_CH(2), .CNT_W(32), .PRESC_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .byteen  (byteen),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, obs, e.exp);
    end
  endtask

  function automatic logic [6:0] a(input int ch, input logic [1:0] r);
    return {3'(ch), r, 2'b00};
  endfunction

  // Cycles from the CTRL write edge to irq: IDLE + LOAD + count phase + INT.
  function automatic int lat_oneshot(input int p, input int s);
    return ((p == 0) ? 1 : p) * (s + 1) + 3;
  endfunction

  function automatic int period_auto(input int p, input int s);
    return ((p == 0) ? 1 : p) * (s + 1) + 2;
  endfunction

  task automatic wr(input logic [6:0] ad, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr   = ad;
    wdata  = d;
    byteen = be;
    we     = 1'b1;
    @(negedge clk);
    we     = 1'b0;
    byteen = 4'b0000;
  endtask

  task automatic rd_check(input logic [6:0] ad, input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    addr = ad;
    #1;
    sb_pop(rdata);
  endtask

  task automatic irq_check(input string tag, input logic [1:0] exp_irq);
    sb_push({tag, "_irq"}, 32'(exp_irq));
    sb_push({tag, "_irq_any"}, 32'(|exp_irq));
    sb_pop(32'(irq));
    sb_pop(32'(irq_any));
  endtask

  task automatic wait_irq(input int ch, input int budget, output int elapsed);
    elapsed = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (irq[ch]) begin
        elapsed = k;
        break;
      end
    end
    if (elapsed < 0) check("irq_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int e1, e2;
    reset  = 1'b0;
    we     = 1'b0;
    addr   = '0;
    wdata  = '0;
    byteen = '0;

    // Writes while reset is held must not land.
    repeat (2) @(negedge clk);
    addr = a(0, REG_CTRL); wdata = 32'hFFFF_FFFF; byteen = 4'hF; we = 1'b1;
    @(negedge clk);
    addr = a(0, REG_PRESET);
    @(negedge clk);
    we = 1'b0;
    rd_check(a(0, REG_CTRL),   "rst_ctrl0",   32'h0);
    rd_check(a(0, REG_PRESET), "rst_preset0", 32'h0);
    rd_check(a(1, REG_CTRL),   "rst_ctrl1",   32'h0);
    irq_check("rst", 2'b00);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rd_check(a(0, REG_CTRL),   "post_rst_ctrl0",   32'h0);
    rd_check(a(0, REG_PRESET), "post_rst_preset0", 32'h0);
    rd_check(a(0, REG_COUNT),  "post_rst_count0",  32'h0);
    rd_check(a(1, REG_STATUS), "post_rst_status1", 32'h0);

    // One-shot on channel 0
    wr(a(0, REG_PRESET), 32'd5, 4'hF);
    wr(a(0, REG_CTRL), 32'h9, 4'hF);
    sb_push("oneshot_latency", 32'(lat_oneshot(5, 0)));
    wait_irq(0, 50, e1);
    sb_pop(32'(e1));
    irq_check("oneshot", 2'b01);
    rd_check(a(0, REG_CTRL),   "oneshot_ctrl",   32'h8);
    rd_check(a(0, REG_COUNT),  "oneshot_count",  32'h0);
    rd_check(a(0, REG_STATUS), "oneshot_status", 32'h1);
    wr(a(0, REG_STATUS), 32'h1, 4'h1);
    irq_check("oneshot_w1c", 2'b00);

    // Auto-reload with prescaler on channel 1
    wr(a(1, REG_PRESET), 32'd3, 4'hF);
    wr(a(1, REG_CTRL), 32'h30B, 4'hF);
    sb_push("auto_first_latency", 32'(lat_oneshot(3, 3)));
    wait_irq(1, 100, e1);
    sb_pop(32'(e1));
    for (int n = 0; n < 2; n++) begin
      wr(a(1, REG_STATUS), 32'h1, 4'h1);
      irq_check("auto_w1c", 2'b00);
      sb_push("auto_period", 32'(period_auto(3, 3)));
      wait_irq(1, 100, e2);
      sb_pop(32'(e2 + 2));
    end
    wr(a(1, REG_CTRL), 32'h302, 4'hF);
    wr(a(1, REG_STATUS), 32'h1, 4'h1);
    irq_check("auto_stop", 2'b00);

    // Mask and aggregate
    wr(a(0, REG_PRESET), 32'd2, 4'hF);
    wr(a(1, REG_PRESET), 32'd2, 4'hF);
    wr(a(0, REG_CTRL), 32'h1, 4'hF);
    wr(a(1, REG_CTRL), 32'h9, 4'hF);
    repeat (20) @(negedge clk);
    irq_check("mask", 2'b10);
    rd_check(a(0, REG_STATUS), "mask_status0", 32'h1);
    rd_check(a(0, REG_CTRL),   "mask_ctrl0",   32'h0);
    wr(a(0, REG_STATUS), 32'h1, 4'h1);
    wr(a(1, REG_STATUS), 32'h1, 4'h1);
    irq_check("mask_clear", 2'b00);

    // Nonexistent channel decode
    wr(a(7, REG_PRESET), 32'hDEAD_BEEF, 4'hF);
    wr(a(7, REG_CTRL), 32'h9, 4'hF);
    rd_check(a(7, REG_PRESET), "ch7_preset", 32'h0);
    rd_check(a(7, REG_CTRL),   "ch7_ctrl",   32'h0);
    rd_check(a(1, REG_PRESET), "ch7_alias_preset1", 32'd2);
    rd_check(a(1, REG_CTRL),   "ch7_alias_ctrl1",   32'h8);
    repeat (10) @(negedge clk);
    irq_check("ch7", 2'b00);

    // Byte enables
    wr(a(0, REG_PRESET), 32'h1234_5678, 4'hF);
    wr(a(0, REG_PRESET), 32'hFFFF_FFAB, 4'h1);
    rd_check(a(0, REG_PRESET), "byteen_preset", 32'h1234_56AB);
    wr(a(0, REG_CTRL), 32'h0000_0301, 4'h2);
    rd_check(a(0, REG_CTRL), "byteen_ctrl", 32'h300);
    wr(a(0, REG_CTRL), 32'h0, 4'hF);

    // W1C landing on the INT edge: set wins
    wr(a(0, REG_PRESET), 32'd4, 4'hF);
    wr(a(0, REG_CTRL), 32'h1, 4'hF);
    repeat (lat_oneshot(4, 0) - 2) @(negedge clk);
    wr(a(0, REG_STATUS), 32'h1, 4'h1);
    rd_check(a(0, REG_STATUS), "w1c_vs_int", 32'h1);
    wr(a(0, REG_STATUS), 32'h1, 4'h1);
    rd_check(a(0, REG_STATUS), "w1c_plain", 32'h0);

    // CTRL write on the INT edge keeps EN
    wr(a(0, REG_PRESET), 32'd2, 4'hF);
    wr(a(0, REG_CTRL), 32'h1, 4'hF);
    repeat (lat_oneshot(2, 0) - 2) @(negedge clk);
    wr(a(0, REG_CTRL), 32'h9, 4'hF);
    rd_check(a(0, REG_CTRL), "ctrl_vs_int", 32'h9);
    wr(a(0, REG_CTRL), 32'h0, 4'hF);
    wr(a(0, REG_STATUS), 32'h1, 4'h1);
    irq_check("ctrl_vs_int_clear", 2'b00);

    // EN=0 mid-count freezes COUNT
    wr(a(0, REG_PRESET), 32'd100, 4'hF);
    wr(a(0, REG_CTRL), 32'h9, 4'hF);
    repeat (10) @(negedge clk);
    wr(a(0, REG_CTRL), 32'h8, 4'hF);
    rd_check(a(0, REG_COUNT), "freeze_count", 32'd90);
    repeat (5) @(negedge clk);
    rd_check(a(0, REG_COUNT), "freeze_count_hold", 32'd90);
    irq_check("freeze", 2'b00);
    rd_check(a(0, REG_STATUS), "freeze_status", 32'h0);

    // Asynchronous reset mid-run
    wr(a(1, REG_PRESET), 32'd3, 4'hF);
    wr(a(1, REG_CTRL), 32'h30B, 4'hF);
    wait_irq(1, 100, e1);
    #2;
    reset = 1'b0;
    #1;
    irq_check("async_rst", 2'b00);
    rd_check(a(1, REG_CTRL),   "async_rst_ctrl1",   32'h0);
    rd_check(a(1, REG_PRESET), "async_rst_preset1", 32'h0);
    rd_check(a(0, REG_PRESET), "async_rst_preset0", 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rd_check(a(1, REG_COUNT), "async_rst_count1", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
